// File: rtl/wdat_3wi_pkg.sv
// Shared types and constants for the per-ASC WDAT 3-wire serializer.
package wdat_3wi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_GAP    = 2'd3
    } state_e;

    localparam int ASC0_FRAME_W  = 77;
    localparam int ASCN_FRAME_W  = 51;
    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_GAP_BITS  = 4;

endpackage

// File: rtl/wdat_3wi_bit_timer.sv
// Bit-period phase counter: produces the sclk level and the end-of-bit tick.
module wdat_3wi_bit_timer
    import wdat_3wi_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk_3wi,
    input  logic rst_3wi,
    input  logic i_start,
    input  logic i_run,
    output logic o_sclk,
    output logic o_bit_end
);

    localparam int D2   = 2 * CLK_DIV;
    localparam int PH_W = $clog2(D2);
    localparam logic [PH_W-1:0] PH_ZERO = {PH_W{1'b0}};
    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1'b1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(D2 - 1);
    localparam logic [PH_W-1:0] PH_HIGH = PH_W'(CLK_DIV);

    logic [PH_W-1:0] r_phase;
    logic [PH_W-1:0] w_phase_nxt;

    // Next phase: restart on accept, wrap at end of bit period, park at 0 when idle.
    always_comb begin
        w_phase_nxt = PH_ZERO;
        if (i_start) begin
            w_phase_nxt = PH_ZERO;
        end else if (i_run) begin
            if (r_phase == PH_LAST) begin
                w_phase_nxt = PH_ZERO;
            end else begin
                w_phase_nxt = r_phase + PH_ONE;
            end
        end else begin
            w_phase_nxt = PH_ZERO;
        end
    end

    // sclk is registered from the next phase so it is low for the first CLK_DIV cycles of a bit.
    always_ff @(posedge clk_3wi or posedge rst_3wi) begin
        if (rst_3wi) begin
            r_phase <= PH_ZERO;
            o_sclk  <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            o_sclk  <= (w_phase_nxt >= PH_HIGH);
        end
    end

    assign o_bit_end = i_run && (r_phase == PH_LAST);

endmodule

// File: rtl/wdat_3wi_serializer.sv
// WDAT frame serializer: MSB-first shift onto the 3-wire interface with
// trailing even-parity bit and an idle gap before the next frame.
module wdat_3wi_serializer
    import wdat_3wi_pkg::*;
#(
    parameter int FRAME_W  = ASC0_FRAME_W,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int GAP_BITS = DEF_GAP_BITS
) (
    input  logic               clk_3wi,
    input  logic               rst_3wi,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic               frame_valid_i,
    output logic               frame_ready_o,
    output logic               sclk_o,
    output logic               wdat_o,
    output logic               wsync_o,
    output logic               done_o,
    output logic [7:0]         frame_cnt_o
);

    localparam int BC_W = $clog2(FRAME_W + 1 + GAP_BITS);
    localparam logic [BC_W-1:0] BC_ZERO      = {BC_W{1'b0}};
    localparam logic [BC_W-1:0] BC_ONE       = BC_W'(1'b1);
    localparam logic [BC_W-1:0] BC_LAST_DATA = BC_W'(FRAME_W - 1);
    localparam logic [BC_W-1:0] BC_LAST_GAP  = BC_W'(FRAME_W + GAP_BITS);

    state_e             r_state;
    logic [FRAME_W-1:0] r_shift;
    logic               r_parity;
    logic [BC_W-1:0]    r_bit_cnt;
    logic               w_accept;
    logic               w_run;
    logic               w_bit_end;

    function automatic logic even_parity(input logic [FRAME_W-1:0] data);
        return ^data;
    endfunction

    assign frame_ready_o = (r_state == ST_IDLE);
    assign w_accept      = frame_valid_i && (r_state == ST_IDLE);
    assign w_run         = (r_state != ST_IDLE);

    wdat_3wi_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clk_3wi   (clk_3wi),
        .rst_3wi   (rst_3wi),
        .i_start   (w_accept),
        .i_run     (w_run),
        .o_sclk    (sclk_o),
        .o_bit_end (w_bit_end)
    );

    // Frame FSM; the bit counter runs 0..FRAME_W-1 for data, FRAME_W for parity, then through the gap.
    always_ff @(posedge clk_3wi or posedge rst_3wi) begin
        if (rst_3wi) begin
            r_state     <= ST_IDLE;
            r_shift     <= {FRAME_W{1'b0}};
            r_parity    <= 1'b0;
            r_bit_cnt   <= BC_ZERO;
            wdat_o      <= 1'b0;
            wsync_o     <= 1'b0;
            done_o      <= 1'b0;
            frame_cnt_o <= 8'd0;
        end else begin
            done_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift   <= {frame_i[FRAME_W-2:0], 1'b0};
                        r_parity  <= even_parity(frame_i);
                        wdat_o    <= frame_i[FRAME_W-1];
                        wsync_o   <= 1'b1;
                        r_bit_cnt <= BC_ZERO;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= r_bit_cnt + BC_ONE;
                        if (r_bit_cnt == BC_LAST_DATA) begin
                            wdat_o  <= r_parity;
                            r_state <= ST_PARITY;
                        end else begin
                            wdat_o  <= r_shift[FRAME_W-1];
                            r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_bit_cnt   <= r_bit_cnt + BC_ONE;
                        wdat_o      <= 1'b0;
                        wsync_o     <= 1'b0;
                        done_o      <= 1'b1;
                        frame_cnt_o <= frame_cnt_o + 8'd1;
                        r_state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == BC_LAST_GAP) begin
                            r_bit_cnt <= BC_ZERO;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BC_ONE;
                        end
                    end
                end
                default: begin
                    r_bit_cnt <= BC_ZERO;
                    wdat_o    <= 1'b0;
                    wsync_o   <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wdat_3wi_serializer.sv
// Bench for wdat_3wi_serializer: one ASC0 (77-bit) and one ASCn (51-bit) instance
// checked every cycle against a timing-rule model, plus directed literal checks.
module tb_wdat_3wi_serializer;

    localparam int CD  = 2;
    localparam int D2  = 2 * CD;
    localparam int GB  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [76:0] f0  = '0;
    logic [50:0] f1  = '0;
    logic        v0  = 1'b0;
    logic        v1  = 1'b0;
    logic        rdy0, sclk0, wd0, ws0, dn0;
    logic        rdy1, sclk1, wd1, ws1, dn1;
    logic [7:0]  cnt0, cnt1;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wdat_3wi_serializer #(.FRAME_W(77), .CLK_DIV(CD), .GAP_BITS(GB)) dut0 (
        .clk_3wi(clk), .rst_3wi(rst), .frame_i(f0), .frame_valid_i(v0),
        .frame_ready_o(rdy0), .sclk_o(sclk0), .wdat_o(wd0), .wsync_o(ws0),
        .done_o(dn0), .frame_cnt_o(cnt0));

    wdat_3wi_serializer #(.FRAME_W(51), .CLK_DIV(CD), .GAP_BITS(GB)) dut1 (
        .clk_3wi(clk), .rst_3wi(rst), .frame_i(f1), .frame_valid_i(v1),
        .frame_ready_o(rdy1), .sclk_o(sclk1), .wdat_o(wd1), .wsync_o(ws1),
        .done_o(dn1), .frame_cnt_o(cnt1));

    task automatic chk(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s dut%0d: got %0h expected %0h at cycle %0d", nm, d, act, exp, cyc);
        end
    endtask

    function automatic int fw(input int d);
        return (d == 0) ? 77 : 51;
    endfunction

    // Array views so the model and compare loop treat both instances alike
    logic [76:0] m_fin [2];
    logic        m_vin [2];
    logic        a_rdy [2], a_sclk [2], a_wd [2], a_ws [2], a_dn [2];
    logic [7:0]  a_cnt [2];
    assign m_fin[0] = f0;
    assign m_fin[1] = {26'd0, f1};
    assign m_vin[0] = v0;
    assign m_vin[1] = v1;
    assign a_rdy[0] = rdy0;  assign a_rdy[1] = rdy1;
    assign a_sclk[0] = sclk0; assign a_sclk[1] = sclk1;
    assign a_wd[0] = wd0;    assign a_wd[1] = wd1;
    assign a_ws[0] = ws0;    assign a_ws[1] = ws1;
    assign a_dn[0] = dn0;    assign a_dn[1] = dn1;
    assign a_cnt[0] = cnt0;  assign a_cnt[1] = cnt1;

    // Model: only "busy since cycle k after accept", the captured frame and a frame count
    logic        m_busy  [2] = '{1'b0, 1'b0};
    int          m_k     [2] = '{0, 0};
    int          m_cnt   [2] = '{0, 0};
    logic [76:0] m_frame [2];
    logic        m_par   [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_busy[d] <= 1'b0;
                m_k[d]    <= 0;
                m_cnt[d]  <= 0;
            end else if (m_busy[d]) begin
                m_k[d] <= m_k[d] + 1;
                if (m_k[d] + 1 == (fw(d) + 1 + GB) * D2) m_busy[d] <= 1'b0;
                if (m_k[d] + 1 == (fw(d) + 1) * D2) m_cnt[d] <= m_cnt[d] + 1;
            end else if (m_vin[d]) begin
                m_busy[d]  <= 1'b1;
                m_k[d]     <= 0;
                m_frame[d] <= m_fin[d];
                m_par[d]   <= ^m_fin[d];
            end
        end
    end

    // Per-cycle comparison of every output of both instances against the model
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int   fwd, b, ph;
            logic e_rdy, e_sclk, e_wd, e_ws, e_dn;
            logic [7:0] e_cnt;
            fwd = fw(d);
            if (rst || !m_busy[d]) begin
                e_rdy = 1'b1; e_sclk = 1'b0; e_wd = 1'b0; e_ws = 1'b0; e_dn = 1'b0;
            end else begin
                b      = m_k[d] / D2;
                ph     = m_k[d] % D2;
                e_rdy  = 1'b0;
                e_sclk = (ph >= CD);
                e_ws   = (b <= fwd);
                if (b < fwd)       e_wd = m_frame[d][fwd - 1 - b];
                else if (b == fwd) e_wd = m_par[d];
                else               e_wd = 1'b0;
                e_dn   = (m_k[d] == (fwd + 1) * D2);
            end
            e_cnt = rst ? 8'd0 : 8'(m_cnt[d] % 256);
            chk("ready", d, 128'(a_rdy[d]), 128'(e_rdy));
            chk("sclk",  d, 128'(a_sclk[d]), 128'(e_sclk));
            chk("wdat",  d, 128'(a_wd[d]), 128'(e_wd));
            chk("wsync", d, 128'(a_ws[d]), 128'(e_ws));
            chk("done",  d, 128'(a_dn[d]), 128'(e_dn));
            chk("count", d, 128'(a_cnt[d]), 128'(e_cnt));
        end
    end

    initial begin
        logic [77:0] rx0;
        logic [51:0] rx1;
        logic [76:0] exp_f;
        logic [76:0] pat;
        logic [95:0] rnd;
        logic        prev;
        int          nrise, nws, dk, n_acc, guard, ndone;
        int          acc [3];

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 0, 128'(rdy0), 128'd1);
        chk("reset_cnt",   0, 128'(cnt0), 128'd0);
        chk("reset_wsync", 1, 128'(ws1),  128'd0);
        chk("reset_sclk",  1, 128'(sclk1), 128'd0);

        // Single 77-bit frame: MSB and LSB set, frame_i scrambled right after accept
        exp_f = (77'd1 << 76) | 77'd1;
        @(posedge clk); #1 f0 = exp_f; v0 = 1'b1;
        @(posedge clk); #1 v0 = 1'b0; f0 = '1;
        rx0 = '0; prev = 1'b0; nrise = 0; nws = 0; dk = -1;
        for (int i = 0; i < 340; i++) begin
            @(negedge clk);
            if (ws0) nws++;
            if (ws0 && sclk0 && !prev) begin rx0 = {rx0[76:0], wd0}; nrise++; end
            prev = sclk0;
            if (dn0) dk = i;
        end
        chk("t1_bits",  0, 128'(rx0), 128'({exp_f, 1'b0}));
        chk("t1_rises", 0, 128'(nrise), 128'd78);
        chk("t1_wsync_cycles", 0, 128'(nws), 128'd312);
        chk("t1_done_at", 0, 128'(dk), 128'd312);
        chk("t1_count", 0, 128'(cnt0), 128'd1);

        // 51-bit all-ones frame: parity must be 1
        @(posedge clk); #1 f1 = '1; v1 = 1'b1;
        @(posedge clk); #1 v1 = 1'b0; f1 = '0;
        rx1 = '0; prev = 1'b0; nrise = 0;
        for (int i = 0; i < 232; i++) begin
            @(negedge clk);
            if (ws1 && sclk1 && !prev) begin rx1 = {rx1[50:0], wd1}; nrise++; end
            prev = sclk1;
        end
        chk("t2_bits",  1, 128'(rx1), 128'({52{1'b1}}));
        chk("t2_rises", 1, 128'(nrise), 128'd52);
        chk("t2_count", 1, 128'(cnt1), 128'd1);

        // Back-to-back frames with valid held high
        @(posedge clk); #1 v0 = 1'b1;
        n_acc = 0; guard = 0;
        while (n_acc < 3 && guard < 1200) begin
            @(negedge clk);
            if (rdy0 && v0) begin acc[n_acc] = cyc; n_acc++; end
            rnd = {$urandom, $urandom, $urandom};
            f0 = rnd[76:0];
            guard++;
        end
        @(posedge clk); #1 v0 = 1'b0;
        chk("t3_accepts", 0, 128'(n_acc), 128'd3);
        if (n_acc == 3) begin
            chk("t3_gap_a", 0, 128'(acc[1] - acc[0]), 128'd329);
            chk("t3_gap_b", 0, 128'(acc[2] - acc[1]), 128'd329);
        end
        repeat (340) @(negedge clk);
        chk("t3_count", 0, 128'(cnt0), 128'd4);

        // Reset during bit 20, held 3 cycles, valid kept high across release
        rnd = {$urandom, $urandom, $urandom};
        @(posedge clk); #1 f0 = rnd[76:0]; v0 = 1'b1;
        @(posedge clk);
        repeat (80) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t4_rst_sclk",  0, 128'(sclk0), 128'd0);
        chk("t4_rst_wdat",  0, 128'(wd0),   128'd0);
        chk("t4_rst_wsync", 0, 128'(ws0),   128'd0);
        chk("t4_rst_done",  0, 128'(dn0),   128'd0);
        chk("t4_rst_ready", 0, 128'(rdy0),  128'd1);
        chk("t4_rst_cnt",   0, 128'(cnt0),  128'd0);
        repeat (3) @(posedge clk);
        pat = 77'h0_A5A5_5A5A_F0F0_0F0F_1234;
        #1 rst = 1'b0; f0 = pat;
        @(posedge clk); #1 v0 = 1'b0; f0 = '0;
        @(negedge clk);
        chk("t4_reaccept_wsync", 0, 128'(ws0), 128'd1);
        chk("t4_reaccept_msb",   0, 128'(wd0), 128'(pat[76]));
        repeat (340) @(negedge clk);
        chk("t4_count", 0, 128'(cnt0), 128'd1);

        // 256 completed frames on the 51-bit instance: count wraps to 0
        @(posedge clk); #1 v1 = 1'b1;
        ndone = 0; guard = 0;
        while (ndone < 256 && guard < 256 * 225 + 200) begin
            @(negedge clk);
            if (dn1) begin
                ndone++;
                if (ndone == 255) chk("t5_cnt255", 1, 128'(cnt1), 128'd255);
                if (ndone == 256) chk("t5_wrap",   1, 128'(cnt1), 128'd0);
            end
            rnd = {$urandom, $urandom, $urandom};
            f1 = rnd[50:0];
            guard++;
        end
        chk("t5_done_pulses", 1, 128'(ndone), 128'd256);
        @(posedge clk); #1 v1 = 1'b0;
        repeat (240) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
